// File: rtl/spi_tx_scheduler_if.sv
// Stream bundle for the SPI transmit scheduler: query request pulses,
// the metadata byte stream, the sample-memory word stream and the single
// outgoing word stream towards the SPI transmitter.
interface spi_tx_scheduler_if;
    logic        query_id;
    logic        query_dataIn;
    logic [31:0] dataIn;

    logic        meta_tvalid;
    logic [7:0]  meta_tdata;
    logic        meta_tlast;
    logic        meta_tready;

    logic        mem_tvalid;
    logic [31:0] mem_tdata;
    logic [3:0]  mem_tkeep;
    logic        mem_tlast;
    logic        mem_tready;

    logic        out_tvalid;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tlast;
    logic        out_tready;

    logic [1:0]  grant;
    logic        busy;

    // Requester / transmitter side.
    modport master (
        output query_id, query_dataIn, dataIn,
        output meta_tvalid, meta_tdata, meta_tlast,
        output mem_tvalid, mem_tdata, mem_tkeep, mem_tlast,
        output out_tready,
        input  meta_tready, mem_tready,
        input  out_tvalid, out_tdata, out_tkeep, out_tlast,
        input  grant, busy
    );

    // Scheduler side.
    modport slave (
        input  query_id, query_dataIn, dataIn,
        input  meta_tvalid, meta_tdata, meta_tlast,
        input  mem_tvalid, mem_tdata, mem_tkeep, mem_tlast,
        input  out_tready,
        output meta_tready, mem_tready,
        output out_tvalid, out_tdata, out_tkeep, out_tlast,
        output grant, busy
    );
endinterface

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: shares the SPI transmit word stream between query
// responses, byte-packed metadata and sample-memory words. Arbitration only
// happens at packet boundaries (IDLE); the output is one registered
// 32-bit valid/ready stream.
module spi_tx_scheduler #(
    parameter int unsigned MEM_BURST = 16,
    parameter logic [31:0] SIG_WORD  = 32'h534c4131
) (
    input  logic              clk,
    input  logic              rst,
    spi_tx_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        META  = 2'd2,
        MEM   = 2'd3
    } state_t;

    localparam int unsigned      CNT_W     = (MEM_BURST > 0) ? $clog2(MEM_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MEM_BURST);

    state_t           state_q, state_d;
    logic             id_pend, din_pend, serve_id;
    logic [1:0]       meta_idx;
    logic [23:0]      meta_acc;
    logic [31:0]      meta_word;
    logic [3:0]       meta_keep;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_done;

    logic             out_tvalid_q;
    logic [31:0]      out_tdata_q;
    logic [3:0]       out_tkeep_q;
    logic             out_tlast_q;

    logic [1:0]       grant_c;
    logic             busy_c, meta_tready_c, mem_tready_c;
    logic             out_hs, meta_hs, mem_hs, meta_flush, query_start;

    assign out_hs      = out_tvalid_q && bus.out_tready;
    assign meta_hs     = meta_tready_c && bus.meta_tvalid;
    assign mem_hs      = mem_tready_c && bus.mem_tvalid;
    assign meta_flush  = meta_hs && ((meta_idx == 2'd3) || bus.meta_tlast);
    assign query_start = (state_q == IDLE) && (id_pend || din_pend);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: fixed-priority pick in IDLE, leave only at packet ends.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (id_pend || din_pend) state_d = QUERY;
                else if (bus.meta_tvalid) state_d = META;
                else if (bus.mem_tvalid)  state_d = MEM;
            end
            QUERY:   if (out_hs) state_d = IDLE;
            META:    if (out_hs && out_tlast_q) state_d = IDLE;
            MEM:     if (out_hs && burst_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the output register.
    always_comb begin
        grant_c       = state_q;
        busy_c        = (state_q != IDLE) || out_tvalid_q;
        meta_tready_c = (state_q == META) && !out_tvalid_q;
        mem_tready_c  = (state_q == MEM) && !out_tvalid_q && !burst_done;
    end

    // Query pending flags: a new pulse wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pend  <= 1'b0;
            din_pend <= 1'b0;
            serve_id <= 1'b0;
        end else begin
            if (query_start) serve_id <= id_pend;
            if (out_hs && (state_q == QUERY)) begin
                if (serve_id) id_pend  <= 1'b0;
                else          din_pend <= 1'b0;
            end
            if (bus.query_id)     id_pend  <= 1'b1;
            if (bus.query_dataIn) din_pend <= 1'b1;
        end
    end

    // Metadata word as it would look with the current byte merged in.
    always_comb begin
        meta_word = {8'h00, meta_acc};
        meta_keep = 4'b0001;
        case (meta_idx)
            2'd0: begin meta_word[7:0]   = bus.meta_tdata; meta_keep = 4'b0001; end
            2'd1: begin meta_word[15:8]  = bus.meta_tdata; meta_keep = 4'b0011; end
            2'd2: begin meta_word[23:16] = bus.meta_tdata; meta_keep = 4'b0111; end
            default: begin meta_word[31:24] = bus.meta_tdata; meta_keep = 4'b1111; end
        endcase
    end

    // Metadata byte packer: lanes fill 0..3; a flush restarts at lane 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_idx <= 2'd0;
            meta_acc <= 24'h0;
        end else if (meta_flush) begin
            meta_idx <= 2'd0;
            meta_acc <= 24'h0;
        end else if (meta_hs) begin
            meta_idx <= meta_idx + 2'd1;
            meta_acc <= meta_word[23:0];
        end
    end

    // Burst counter: restarts on every MEM entry, ends on tlast or the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else if (state_q != MEM) begin
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else if (mem_hs) begin
            burst_cnt  <= burst_cnt + CNT_W'(1);
            burst_done <= bus.mem_tlast ||
                          ((MEM_BURST > 0) && ((burst_cnt + CNT_W'(1)) == BURST_MAX));
        end
    end

    // Output register: loads only while empty, holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= 32'h0;
            out_tkeep_q  <= 4'h0;
            out_tlast_q  <= 1'b0;
        end else begin
            if (out_hs) out_tvalid_q <= 1'b0;
            if (query_start) begin
                out_tvalid_q <= 1'b1;
                out_tdata_q  <= id_pend ? SIG_WORD : bus.dataIn;
                out_tkeep_q  <= 4'hF;
                out_tlast_q  <= 1'b1;
            end else if (meta_flush) begin
                out_tvalid_q <= 1'b1;
                out_tdata_q  <= meta_word;
                out_tkeep_q  <= meta_keep;
                out_tlast_q  <= bus.meta_tlast;
            end else if (mem_hs) begin
                out_tvalid_q <= 1'b1;
                out_tdata_q  <= bus.mem_tdata;
                out_tkeep_q  <= bus.mem_tkeep;
                out_tlast_q  <= bus.mem_tlast;
            end
        end
    end

    assign bus.meta_tready = meta_tready_c;
    assign bus.mem_tready  = mem_tready_c;
    assign bus.out_tvalid  = out_tvalid_q;
    assign bus.out_tdata   = out_tdata_q;
    assign bus.out_tkeep   = out_tkeep_q;
    assign bus.out_tlast   = out_tlast_q;
    assign bus.grant       = grant_c;
    assign bus.busy        = busy_c;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Testbench for spi_tx_scheduler: directed scenarios plus randomized
// metadata blocks, sample captures and dataIn queries, checked against a
// packet-level reference model of the expected output word sequence.
module tb_spi_tx_scheduler;
    localparam int unsigned MEM_BURST = 4;
    localparam logic [31:0] SIG       = 32'h534c4131;

    typedef struct packed {
        logic [1:0]  grant;
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } mbyte_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } mword_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_tx_scheduler_if bus();

    spi_tx_scheduler #(.MEM_BURST(MEM_BURST), .SIG_WORD(SIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_cmp;
    int     n_bad;
    int     rdy_pct;
    word_t  exp_q[$];
    word_t  got_q[$];
    mbyte_t meta_src[$];
    mword_t mem_src[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input logic [1:0] g, input logic l, input logic [3:0] k,
                                 input logic [31:0] d);
        word_t w;
        w.grant = g; w.last = l; w.keep = k; w.data = d;
        return w;
    endfunction

    function automatic word_t cur_word();
        return mk(bus.grant, bus.out_tlast, bus.out_tkeep, bus.out_tdata);
    endfunction

    task automatic drive_sources();
        if (meta_src.size() > 0) begin
            bus.meta_tvalid = 1'b1;
            bus.meta_tdata  = meta_src[0].b;
            bus.meta_tlast  = meta_src[0].last;
        end else begin
            bus.meta_tvalid = 1'b0;
            bus.meta_tdata  = 8'h00;
            bus.meta_tlast  = 1'b0;
        end
        if (mem_src.size() > 0) begin
            bus.mem_tvalid = 1'b1;
            bus.mem_tdata  = mem_src[0].data;
            bus.mem_tkeep  = mem_src[0].keep;
            bus.mem_tlast  = mem_src[0].last;
        end else begin
            bus.mem_tvalid = 1'b0;
            bus.mem_tdata  = 32'h0;
            bus.mem_tkeep  = 4'h0;
            bus.mem_tlast  = 1'b0;
        end
        bus.out_tready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    // One clock: observe handshakes mid-cycle, then update sources after the edge.
    task automatic tick();
        logic m_hs, w_hs;
        @(negedge clk);
        m_hs = bus.meta_tvalid && bus.meta_tready && rst;
        w_hs = bus.mem_tvalid && bus.mem_tready && rst;
        if (bus.out_tvalid && bus.out_tready && rst) got_q.push_back(cur_word());
        @(posedge clk);
        #1;
        if (m_hs) void'(meta_src.pop_front());
        if (w_hs) void'(mem_src.pop_front());
        bus.query_id     = 1'b0;
        bus.query_dataIn = 1'b0;
        drive_sources();
    endtask

    // Wait (bounded) for the expected words, compare in order, confirm no extras.
    task automatic compare_words(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < budget) begin
            tick();
            cyc++;
        end
        repeat (4) tick();
        check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s word%0d", tag, i),
                  (i < got_q.size()) ? 64'(got_q[i]) : 64'bx, 64'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic queue_meta(input logic [7:0] bytes[$]);
        mbyte_t mb;
        for (int i = 0; i < bytes.size(); i++) begin
            mb.b    = bytes[i];
            mb.last = (i == bytes.size() - 1);
            meta_src.push_back(mb);
        end
    endtask

    // Reference: bytes packed little-endian in groups of four, block end closes a word.
    task automatic model_meta(input logic [7:0] bytes[$]);
        logic [31:0] d;
        logic [3:0]  k;
        int          lane;
        d = 0; k = 0; lane = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            d = d | (32'(bytes[i]) << (8 * lane));
            k[lane] = 1'b1;
            lane++;
            if (lane == 4 || i == bytes.size() - 1) begin
                exp_q.push_back(mk(2'd2, i == bytes.size() - 1, k, d));
                d = 0; k = 0; lane = 0;
            end
        end
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] bytes[$]);
        bytes.delete();
        for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0]  bytes[$];
        mword_t      mw;
        logic [31:0] din;
        int          cyc, n;

        n_cmp = 0; n_bad = 0; rdy_pct = 100;
        rst = 1'b0;
        bus.query_id = 1'b0; bus.query_dataIn = 1'b0; bus.dataIn = 32'h0;
        drive_sources();
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("reset word", 64'(cur_word()), 64'(0));
        check("reset tvalid", 64'(bus.out_tvalid), 64'(0));
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset meta_tready", 64'(bus.meta_tready), 64'(0));
        check("reset mem_tready", 64'(bus.mem_tready), 64'(0));
        rst = 1'b1;
        tick();

        // Single ID query: two-cycle latency, then back to idle.
        bus.query_id = 1'b1;
        tick();
        check("id lat1 tvalid", 64'(bus.out_tvalid), 64'(0));
        tick();
        check("id lat2 tvalid", 64'(bus.out_tvalid), 64'(1));
        check("id lat2 word", 64'(cur_word()), 64'(mk(2'd1, 1'b1, 4'hF, SIG)));
        tick();
        check("id post busy", 64'(bus.busy), 64'(0));
        check("id post grant", 64'(bus.grant), 64'(0));
        exp_q.push_back(mk(2'd1, 1'b1, 4'hF, SIG));
        compare_words("id", 50);

        // Both queries in one cycle: ID first, then dataIn.
        bus.dataIn = 32'hDEADBEEF;
        bus.query_id = 1'b1; bus.query_dataIn = 1'b1;
        tick();
        exp_q.push_back(mk(2'd1, 1'b1, 4'hF, SIG));
        exp_q.push_back(mk(2'd1, 1'b1, 4'hF, 32'hDEADBEEF));
        compare_words("id+din", 50);

        // Directed metadata block 01..05.
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        queue_meta(bytes);
        tick();
        exp_q.push_back(mk(2'd2, 1'b0, 4'hF, 32'h04030201));
        exp_q.push_back(mk(2'd2, 1'b1, 4'h1, 32'h00000005));
        compare_words("meta5", 100);
        check("meta5 idle grant", 64'(bus.grant), 64'(0));

        // Ten sample words, ID query after the 2nd one leaves: bursts of four.
        for (int i = 1; i <= 10; i++) begin
            mw.data = 32'hA000_0000 + 32'(i); mw.keep = 4'hF; mw.last = (i == 10);
            mem_src.push_back(mw);
        end
        cyc = 0;
        while (got_q.size() < 2 && cyc < 100) begin tick(); cyc++; end
        bus.query_id = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(mk(2'd3, i == 10, 4'hF, 32'hA000_0000 + 32'(i)));
            if (i == 4) exp_q.push_back(mk(2'd1, 1'b1, 4'hF, SIG));
        end
        compare_words("burst", 200);

        // Stall 20 cycles mid-metadata.
        rdy_pct = 0;
        rand_bytes(9, bytes);
        queue_meta(bytes);
        model_meta(bytes);
        cyc = 0;
        while (!bus.out_tvalid && cyc < 50) begin tick(); cyc++; end
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall word c%0d", i), 64'(cur_word()), 64'(exp_q[0]));
            check($sformatf("stall meta_tready c%0d", i), 64'(bus.meta_tready), 64'(0));
            tick();
        end
        rdy_pct = 100;
        compare_words("stall", 200);

        // Randomized blocks, captures and dataIn queries.
        for (int it = 0; it < 8; it++) begin
            rdy_pct = int'($urandom_range(100, 30));
            rand_bytes(int'($urandom_range(11, 1)), bytes);
            queue_meta(bytes);
            model_meta(bytes);
            compare_words($sformatf("rmeta%0d", it), 600);

            n = int'($urandom_range(13, 1));
            for (int i = 0; i < n; i++) begin
                mw.data = $urandom; mw.keep = 4'($urandom); mw.last = (i == n - 1);
                mem_src.push_back(mw);
                exp_q.push_back(mk(2'd3, mw.last, mw.keep, mw.data));
            end
            compare_words($sformatf("rmem%0d", it), 600);

            din = $urandom;
            bus.dataIn = din;
            bus.query_dataIn = 1'b1;
            tick();
            exp_q.push_back(mk(2'd1, 1'b1, 4'hF, din));
            compare_words($sformatf("rdin%0d", it), 100);
        end

        // Reset in the middle of a stalled MEM word; pulses during reset are lost.
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) begin
            mw.data = 32'hC0DE_0000 + 32'(i); mw.keep = 4'hF; mw.last = (i == 2);
            mem_src.push_back(mw);
        end
        cyc = 0;
        while (!bus.out_tvalid && cyc < 50) begin tick(); cyc++; end
        check("prerst tvalid", 64'(bus.out_tvalid), 64'(1));
        check("prerst grant", 64'(bus.grant), 64'(3));
        #2;
        rst = 1'b0;
        #1;
        check("rst word", 64'(cur_word()), 64'(0));
        check("rst tvalid", 64'(bus.out_tvalid), 64'(0));
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst mem_tready", 64'(bus.mem_tready), 64'(0));
        mem_src.delete();
        bus.query_id = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("postrst grant", 64'(bus.grant), 64'(0));
        check("postrst tvalid", 64'(bus.out_tvalid), 64'(0));
        check("postrst words", 64'(got_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Shares the single SPI transmit word stream between three requesters: query responses (ID signature / dataIn snapshot), metadata bytes, and sample-memory words.
- Packs byte-wide metadata into 32-bit words with byte-enables.
- Arbitrates at packet boundaries and drives one registered 32-bit valid/ready stream into the SPI transmitter's sample input.

Parameters:
- MEM_BURST, 16, max sample words per MEM grant before re-arbitration; 0 = unlimited (until mem_tlast).
- SIG_WORD, 32'h534c4131, word returned for query_id ("SLA1").

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- query_id  in  1  single-cycle request: send SIG_WORD
- query_dataIn  in  1  single-cycle request: send dataIn
- dataIn  in  32  input snapshot, sampled when the query_dataIn word is loaded
- meta_tvalid  in  1  metadata byte valid
- meta_tdata  in  8  metadata byte
- meta_tlast  in  1  last byte of metadata block
- meta_tready  out  1  metadata byte accepted
- mem_tvalid  in  1  sample word valid
- mem_tdata  in  32  sample word
- mem_tkeep  in  4  sample byte enables
- mem_tlast  in  1  last word of capture
- mem_tready  out  1  sample word accepted
- out_tvalid  out  1  word to SPI transmitter valid
- out_tdata  out  32  word; byte0 = [7:0], sent first
- out_tkeep  out  4  byte enables
- out_tlast  out  1  last word of packet
- out_tready  in  1  transmitter accepts word
- grant  out  2  0 none, 1 query, 2 meta, 3 mem
- busy  out  1  state!=IDLE or out_tvalid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pending flags, byte index and burst counter cleared. Query pulses during reset are lost.
- Pending flags:
  - id_pend and din_pend set on query_id / query_dataIn pulses in any state.
  - A flag is cleared only when its word handshakes on out.
  - A pulse for an already-pending flag merges into that flag.
- Output register: out_* change only when out_tvalid=0 or on the cycle out_tvalid&&out_tready. Held stable while stalled.
- FSM states: IDLE, QUERY, META, MEM. grant mirrors state.
- Arbitration in IDLE is fixed priority: id_pend > din_pend > meta_tvalid > mem_tvalid.
- IDLE -> QUERY:
  - Next cycle out_tvalid=1 with out_tdata = SIG_WORD (or dataIn sampled that cycle), out_tkeep=F, out_tlast=1.
  - Latency: query pulse to out_tvalid is 2 cycles when IDLE.
- QUERY:
  - On handshake, clear the served flag and go to IDLE.
  - If id and dataIn are both pending, ID goes first, then dataIn after a return through IDLE.
- META:
  - meta_tready = (state==META) && !out_tvalid.
  - Accepted bytes fill lanes 0..3 in order (2-bit index); unfilled lanes read 0.
  - When the 4th byte or a tlast byte is accepted, present the word next cycle: tkeep = filled lanes (1 byte -> 0001, 3 bytes -> 0111), out_tlast = meta_tlast. Index resets.
  - After handshake: go to IDLE if that word had tlast, else stay in META.
  - The metadata block is atomic: queries wait.
- MEM:
  - mem_tready = (state==MEM) && !out_tvalid && !burst_done.
  - Accepted word is copied to out next cycle with the same tdata/tkeep/tlast. Throughput is 1 word per 2 cycles minimum.
  - Burst counter counts accepted words and is cleared on entry.
  - burst_done when mem_tlast is accepted or count==MEM_BURST (MEM_BURST>0).
  - After the handshake of the final word, go to IDLE. A pending query then preempts the remaining capture, and MEM resumes later.
- mem_tkeep=0 words pass unchanged (the transmitter skips them).
- No source valid in IDLE: stay IDLE, out_tvalid=0.
- Illegal state encoding -> IDLE.

Test Plan:
- Reset then query_id pulse, out_tready=1 -> 2 cycles later out_tdata=534c4131, tkeep=F, tlast=1, grant=1; busy=0 after handshake.
- query_id and query_dataIn in the same cycle, dataIn=DEADBEEF -> two words in order: 534c4131 then DEADBEEF; each has tlast=1.
- Meta bytes 01,02,03,04,05(tlast) -> word 04030201 tkeep=F tlast=0, then 00000005 tkeep=1 tlast=1; then IDLE.
- MEM_BURST=4, 10 mem words ready, query_id pulsed after the 2nd word -> words 1-4, then SIG word, then words 5-8, then 9-10; tlast is preserved on word 10 only.
- out_tready held 0 for 20 cycles mid-meta -> out_* stable and meta_tready=0 throughout; no byte lost or duplicated after release.
- rst asserted mid-MEM with out_tvalid=1 -> outputs 0 immediately; after release, grant=0 until a new request.
